// File: rtl/multi_cycle_controller.sv
// Multi-cycle CPU controller.
// Moore FSM that sequences the shared datapath (one memory port, one ALU,
// IR and PC). Opcode is decoded from the already-registered IR in DECODE
// only. A mem_ready handshake stalls FETCH, MEMRD and MEMWR. The block also
// latches instruction-type flags, counts retired instructions and traps on
// illegal opcodes.
//
// The control outputs are registered. Each register is loaded with the
// decode of the *next* state, so every output is a clean flop that always
// matches the current state code. The one exception is FETCH: ir_write and
// pc_write follow mem_ready in the same cycle. They are formed by ANDing a
// registered "in FETCH" bit with mem_ready.
module multi_cycle_controller #(
  parameter int CNT_W   = 8,
  parameter bit TRAP_EN = 1'b1
) (
  input  logic             hand_clock,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_source,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [3:0]       state,
  output logic             flag_j,
  output logic             flag_r,
  output logic             flag_lw,
  output logic             flag_sw,
  output logic             flag_beq,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    EXEC   = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9,
    JUMP   = 4'd10,
    TRAP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Current state and registered outputs
  state_t           state_r;
  logic             fetch_r;
  logic             pc_write_r;
  logic             pc_write_cond_r;
  logic [1:0]       pc_source_r;
  logic             iord_r;
  logic             mem_read_r;
  logic             mem_write_r;
  logic             mem_to_reg_r;
  logic             reg_dst_r;
  logic             reg_write_r;
  logic             alu_src_a_r;
  logic [1:0]       alu_src_b_r;
  logic [1:0]       alu_op_r;
  logic             halted_r;
  logic             flag_j_r;
  logic             flag_r_r;
  logic             flag_lw_r;
  logic             flag_sw_r;
  logic             flag_beq_r;
  logic [CNT_W-1:0] retired_r;

  // Combinational next values
  state_t           next_state_s;
  logic             retire_s;
  logic             fetch_s;
  logic             pc_write_s;
  logic             pc_write_cond_s;
  logic [1:0]       pc_source_s;
  logic             iord_s;
  logic             mem_read_s;
  logic             mem_write_s;
  logic             mem_to_reg_s;
  logic             reg_dst_s;
  logic             reg_write_s;
  logic             alu_src_a_s;
  logic [1:0]       alu_src_b_s;
  logic [1:0]       alu_op_s;
  logic             halted_s;
  logic [4:0]       dec_flags_s;

  // One-hot instruction type {j, r, lw, sw, beq}. All zero means illegal.
  function automatic logic [4:0] decode_type(input logic [5:0] op);
    logic [4:0] t;
    t = 5'b00000;
    case (op)
      OP_J:    t = 5'b10000;
      OP_R:    t = 5'b01000;
      OP_LW:   t = 5'b00100;
      OP_SW:   t = 5'b00010;
      OP_BEQ:  t = 5'b00001;
      default: t = 5'b00000;
    endcase
    return t;
  endfunction

  // Decode the opcode into type flags; used only when leaving DECODE
  always_comb begin
    dec_flags_s = decode_type(opcode);
  end

  // Next-state selection
  always_comb begin
    next_state_s = IDLE;
    case (state_r)
      IDLE: next_state_s = FETCH;
      FETCH: begin
        if (mem_ready) begin
          next_state_s = DECODE;
        end else begin
          next_state_s = FETCH;
        end
      end
      DECODE: begin
        case (opcode)
          OP_R:          next_state_s = EXEC;
          OP_LW, OP_SW:  next_state_s = MEMADR;
          OP_BEQ:        next_state_s = BRANCH;
          OP_J:          next_state_s = JUMP;
          default: begin
            if (TRAP_EN) begin
              next_state_s = TRAP;
            end else begin
              next_state_s = FETCH;
            end
          end
        endcase
      end
      MEMADR: begin
        // The type was latched on the DECODE exit edge, so the flags are valid here
        if (flag_lw_r) begin
          next_state_s = MEMRD;
        end else if (flag_sw_r) begin
          next_state_s = MEMWR;
        end else begin
          next_state_s = FETCH;
        end
      end
      MEMRD: begin
        if (mem_ready) begin
          next_state_s = MEMWB;
        end else begin
          next_state_s = MEMRD;
        end
      end
      MEMWB: next_state_s = FETCH;
      MEMWR: begin
        if (mem_ready) begin
          next_state_s = FETCH;
        end else begin
          next_state_s = MEMWR;
        end
      end
      EXEC:    next_state_s = ALUWB;
      ALUWB:   next_state_s = FETCH;
      BRANCH:  next_state_s = FETCH;
      JUMP:    next_state_s = FETCH;
      TRAP:    next_state_s = TRAP;
      default: next_state_s = IDLE;
    endcase
  end

  // An instruction retires on the edge that leaves its final state
  always_comb begin
    retire_s = 1'b0;
    case (state_r)
      MEMWB, ALUWB, BRANCH, JUMP: retire_s = 1'b1;
      MEMWR:                      retire_s = mem_ready;
      default:                    retire_s = 1'b0;
    endcase
  end

  // Control decode of the state being entered, loaded into the output flops
  always_comb begin
    fetch_s         = 1'b0;
    pc_write_s      = 1'b0;
    pc_write_cond_s = 1'b0;
    pc_source_s     = 2'b00;
    iord_s          = 1'b0;
    mem_read_s      = 1'b0;
    mem_write_s     = 1'b0;
    mem_to_reg_s    = 1'b0;
    reg_dst_s       = 1'b0;
    reg_write_s     = 1'b0;
    alu_src_a_s     = 1'b0;
    alu_src_b_s     = 2'b00;
    alu_op_s        = 2'b00;
    halted_s        = 1'b0;
    case (next_state_s)
      FETCH: begin
        fetch_s     = 1'b1;
        mem_read_s  = 1'b1;
        alu_src_b_s = 2'b01;
      end
      DECODE: begin
        alu_src_b_s = 2'b11;
      end
      MEMADR: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
      end
      MEMRD: begin
        mem_read_s = 1'b1;
        iord_s     = 1'b1;
      end
      MEMWB: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = 1'b1;
      end
      MEMWR: begin
        mem_write_s = 1'b1;
        iord_s      = 1'b1;
      end
      EXEC: begin
        alu_src_a_s = 1'b1;
        alu_op_s    = 2'b10;
      end
      ALUWB: begin
        reg_write_s = 1'b1;
        reg_dst_s   = 1'b1;
      end
      BRANCH: begin
        alu_src_a_s     = 1'b1;
        alu_op_s        = 2'b01;
        pc_write_cond_s = 1'b1;
        pc_source_s     = 2'b01;
      end
      JUMP: begin
        pc_write_s  = 1'b1;
        pc_source_s = 2'b10;
      end
      TRAP: begin
        halted_s = 1'b1;
      end
      default: begin
        fetch_s = 1'b0;
      end
    endcase
  end

  // FSM state, registered controls, type flags and retired counter
  always_ff @(posedge hand_clock or posedge reset) begin
    if (reset) begin
      state_r         <= IDLE;
      fetch_r         <= 1'b0;
      pc_write_r      <= 1'b0;
      pc_write_cond_r <= 1'b0;
      pc_source_r     <= 2'b00;
      iord_r          <= 1'b0;
      mem_read_r      <= 1'b0;
      mem_write_r     <= 1'b0;
      mem_to_reg_r    <= 1'b0;
      reg_dst_r       <= 1'b0;
      reg_write_r     <= 1'b0;
      alu_src_a_r     <= 1'b0;
      alu_src_b_r     <= 2'b00;
      alu_op_r        <= 2'b00;
      halted_r        <= 1'b0;
      flag_j_r        <= 1'b0;
      flag_r_r        <= 1'b0;
      flag_lw_r       <= 1'b0;
      flag_sw_r       <= 1'b0;
      flag_beq_r      <= 1'b0;
      retired_r       <= {CNT_W{1'b0}};
    end else begin
      state_r         <= next_state_s;
      fetch_r         <= fetch_s;
      pc_write_r      <= pc_write_s;
      pc_write_cond_r <= pc_write_cond_s;
      pc_source_r     <= pc_source_s;
      iord_r          <= iord_s;
      mem_read_r      <= mem_read_s;
      mem_write_r     <= mem_write_s;
      mem_to_reg_r    <= mem_to_reg_s;
      reg_dst_r       <= reg_dst_s;
      reg_write_r     <= reg_write_s;
      alu_src_a_r     <= alu_src_a_s;
      alu_src_b_r     <= alu_src_b_s;
      alu_op_r        <= alu_op_s;
      halted_r        <= halted_s;
      if (state_r == DECODE) begin
        {flag_j_r, flag_r_r, flag_lw_r, flag_sw_r, flag_beq_r} <= dec_flags_s;
      end
      if (retire_s) begin
        retired_r <= retired_r + CNT_ONE;
      end
    end
  end

  // FETCH strobes track mem_ready within the cycle; everything else is a flop
  assign ir_write      = fetch_r & mem_ready;
  assign pc_write      = pc_write_r | (fetch_r & mem_ready);
  assign pc_write_cond = pc_write_cond_r;
  assign pc_source     = pc_source_r;
  assign iord          = iord_r;
  assign mem_read      = mem_read_r;
  assign mem_write     = mem_write_r;
  assign mem_to_reg    = mem_to_reg_r;
  assign reg_dst       = reg_dst_r;
  assign reg_write     = reg_write_r;
  assign alu_src_a     = alu_src_a_r;
  assign alu_src_b     = alu_src_b_r;
  assign alu_op        = alu_op_r;
  assign state         = state_r;
  assign flag_j        = flag_j_r;
  assign flag_r        = flag_r_r;
  assign flag_lw       = flag_lw_r;
  assign flag_sw       = flag_sw_r;
  assign flag_beq      = flag_beq_r;
  assign halted        = halted_r;
  assign retired       = retired_r;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Testbench for multi_cycle_controller.
// Two instances share the same stimulus: "a" traps on illegal opcodes and
// "b" skips them. Expected behaviour comes from an instruction-level model:
// each instruction expands into a per-cycle list of states and mem_ready
// values, and the spec's per-state control table supplies the outputs.
module tb_multi_cycle_controller;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;

  logic       hand_clock = 1'b0;
  logic       reset = 1'b1;
  logic       mem_ready = 1'b0;
  logic [5:0] opcode = 6'd0;

  wire        pc_write_a, pc_write_cond_a, iord_a, mem_read_a, mem_write_a, ir_write_a;
  wire        mem_to_reg_a, reg_dst_a, reg_write_a, alu_src_a_a, halted_a;
  wire [1:0]  pc_source_a, alu_src_b_a, alu_op_a;
  wire [3:0]  state_a;
  wire        flag_j_a, flag_r_a, flag_lw_a, flag_sw_a, flag_beq_a;
  wire [7:0]  retired_a;

  wire        pc_write_b, pc_write_cond_b, iord_b, mem_read_b, mem_write_b, ir_write_b;
  wire        mem_to_reg_b, reg_dst_b, reg_write_b, alu_src_a_b, halted_b;
  wire [1:0]  pc_source_b, alu_src_b_b, alu_op_b;
  wire [3:0]  state_b;
  wire        flag_j_b, flag_r_b, flag_lw_b, flag_sw_b, flag_beq_b;
  wire [7:0]  retired_b;

  multi_cycle_controller #(.CNT_W(8), .TRAP_EN(1'b1)) dut_a (
    .hand_clock(hand_clock), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write_a), .pc_write_cond(pc_write_cond_a), .pc_source(pc_source_a),
    .iord(iord_a), .mem_read(mem_read_a), .mem_write(mem_write_a), .ir_write(ir_write_a),
    .mem_to_reg(mem_to_reg_a), .reg_dst(reg_dst_a), .reg_write(reg_write_a),
    .alu_src_a(alu_src_a_a), .alu_src_b(alu_src_b_a), .alu_op(alu_op_a), .state(state_a),
    .flag_j(flag_j_a), .flag_r(flag_r_a), .flag_lw(flag_lw_a), .flag_sw(flag_sw_a),
    .flag_beq(flag_beq_a), .halted(halted_a), .retired(retired_a)
  );

  multi_cycle_controller #(.CNT_W(8), .TRAP_EN(1'b0)) dut_b (
    .hand_clock(hand_clock), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write_b), .pc_write_cond(pc_write_cond_b), .pc_source(pc_source_b),
    .iord(iord_b), .mem_read(mem_read_b), .mem_write(mem_write_b), .ir_write(ir_write_b),
    .mem_to_reg(mem_to_reg_b), .reg_dst(reg_dst_b), .reg_write(reg_write_b),
    .alu_src_a(alu_src_a_b), .alu_src_b(alu_src_b_b), .alu_op(alu_op_b), .state(state_b),
    .flag_j(flag_j_b), .flag_r(flag_r_b), .flag_lw(flag_lw_b), .flag_sw(flag_sw_b),
    .flag_beq(flag_beq_b), .halted(halted_b), .retired(retired_b)
  );

  always #5 hand_clock = ~hand_clock;

  // Bit layout: pc_write, pc_write_cond, pc_source[2], iord, mem_read, mem_write,
  // ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[2], alu_op[2], halted
  wire [16:0] ctrl_a = {pc_write_a, pc_write_cond_a, pc_source_a, iord_a, mem_read_a,
                        mem_write_a, ir_write_a, mem_to_reg_a, reg_dst_a, reg_write_a,
                        alu_src_a_a, alu_src_b_a, alu_op_a, halted_a};
  wire [16:0] ctrl_b = {pc_write_b, pc_write_cond_b, pc_source_b, iord_b, mem_read_b,
                        mem_write_b, ir_write_b, mem_to_reg_b, reg_dst_b, reg_write_b,
                        alu_src_a_b, alu_src_b_b, alu_op_b, halted_b};
  wire [4:0]  flags_a = {flag_j_a, flag_r_a, flag_lw_a, flag_sw_a, flag_beq_a};
  wire [4:0]  flags_b = {flag_j_b, flag_r_b, flag_lw_b, flag_sw_b, flag_beq_b};

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_retired = 8'd0;
  logic [4:0] exp_flags = 5'd0;

  // Spec table: controls for a state code (FETCH strobes follow mem_ready)
  function automatic logic [16:0] exp_ctrl(input logic [3:0] st, input logic rdy);
    logic pw, pwc, io, mr, mw, irw, m2r, rd, rw, sa, hl;
    logic [1:0] ps, sb, op;
    {pw, pwc, io, mr, mw, irw, m2r, rd, rw, sa, hl} = 11'd0;
    ps = 2'b00; sb = 2'b00; op = 2'b00;
    case (st)
      4'd1:  begin mr = 1'b1; sb = 2'b01; irw = rdy; pw = rdy; end
      4'd2:  sb = 2'b11;
      4'd3:  begin sa = 1'b1; sb = 2'b10; end
      4'd4:  begin mr = 1'b1; io = 1'b1; end
      4'd5:  begin rw = 1'b1; m2r = 1'b1; end
      4'd6:  begin mw = 1'b1; io = 1'b1; end
      4'd7:  begin sa = 1'b1; op = 2'b10; end
      4'd8:  begin rw = 1'b1; rd = 1'b1; end
      4'd9:  begin sa = 1'b1; op = 2'b01; pwc = 1'b1; ps = 2'b01; end
      4'd10: begin pw = 1'b1; ps = 2'b10; end
      4'd11: hl = 1'b1;
      default: hl = 1'b0;
    endcase
    return {pw, pwc, ps, io, mr, mw, irw, m2r, rd, rw, sa, sb, op, hl};
  endfunction

  function automatic logic [4:0] type_flags(input logic [5:0] op);
    case (op)
      OP_J:    return 5'b10000;
      OP_R:    return 5'b01000;
      OP_LW:   return 5'b00100;
      OP_SW:   return 5'b00010;
      OP_BEQ:  return 5'b00001;
      default: return 5'b00000;
    endcase
  endfunction

  // Reset both instances, sit through IDLE, and leave at posedge+1 in FETCH
  task automatic apply_reset();
    reset = 1'b1;
    #1;
    @(posedge hand_clock); #1;
    reset = 1'b0;
    mem_ready = 1'($urandom);
    opcode = 6'($urandom);
    @(posedge hand_clock); #1;
    exp_retired = 8'd0;
    exp_flags = 5'd0;
  endtask

  // Run one legal instruction from FETCH with fst FETCH stalls and mst
  // memory stalls. The model expands it to a per-cycle state trace.
  task automatic run_instr(input logic [5:0] op, input int fst, input int mst);
    logic [3:0] sq[$];
    logic       rq[$];
    for (int i = 0; i < fst; i++) begin sq.push_back(4'd1); rq.push_back(1'b0); end
    sq.push_back(4'd1); rq.push_back(1'b1);
    sq.push_back(4'd2); rq.push_back(1'($urandom));
    case (op)
      OP_R:   begin sq.push_back(4'd7); rq.push_back(1'($urandom));
                    sq.push_back(4'd8); rq.push_back(1'($urandom)); end
      OP_LW:  begin sq.push_back(4'd3); rq.push_back(1'($urandom));
                    for (int i = 0; i < mst; i++) begin sq.push_back(4'd4); rq.push_back(1'b0); end
                    sq.push_back(4'd4); rq.push_back(1'b1);
                    sq.push_back(4'd5); rq.push_back(1'($urandom)); end
      OP_SW:  begin sq.push_back(4'd3); rq.push_back(1'($urandom));
                    for (int i = 0; i < mst; i++) begin sq.push_back(4'd6); rq.push_back(1'b0); end
                    sq.push_back(4'd6); rq.push_back(1'b1); end
      OP_BEQ: begin sq.push_back(4'd9); rq.push_back(1'($urandom)); end
      default: begin sq.push_back(4'd10); rq.push_back(1'($urandom)); end
    endcase
    for (int i = 0; i < sq.size(); i++) begin
      mem_ready = rq[i];
      opcode = (sq[i] == 4'd2) ? op : 6'($urandom);
      #1;
      checks++;
      if (state_a !== sq[i]) begin
        errors++; $display("FAIL state op=%b cyc=%0d: got %0d want %0d", op, i, state_a, sq[i]);
      end
      checks++;
      if (state_b !== sq[i]) begin
        errors++; $display("FAIL state_b op=%b cyc=%0d: got %0d want %0d", op, i, state_b, sq[i]);
      end
      checks++;
      if (ctrl_a !== exp_ctrl(sq[i], rq[i])) begin
        errors++; $display("FAIL ctrl op=%b cyc=%0d st=%0d: got %b want %b", op, i, sq[i], ctrl_a, exp_ctrl(sq[i], rq[i]));
      end
      checks++;
      if (flags_a !== exp_flags) begin
        errors++; $display("FAIL flags op=%b cyc=%0d: got %b want %b", op, i, flags_a, exp_flags);
      end
      checks++;
      if (retired_a !== exp_retired) begin
        errors++; $display("FAIL retired op=%b cyc=%0d: got %0d want %0d", op, i, retired_a, exp_retired);
      end
      if (sq[i] == 4'd2) exp_flags = type_flags(op);
      @(posedge hand_clock); #1;
    end
    exp_retired = exp_retired + 8'd1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (state_a !== 4'd0 || ctrl_a !== 17'd0 || flags_a !== 5'd0 || retired_a !== 8'd0) begin
      errors++; $display("FAIL reset_state: st=%0d ctrl=%b flags=%b ret=%0d want all 0", state_a, ctrl_a, flags_a, retired_a);
    end
    @(posedge hand_clock); #1;
    reset = 1'b0;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (state_a !== 4'd0) begin
      errors++; $display("FAIL idle_state: got %0d want 0", state_a);
    end
    @(posedge hand_clock); #1;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (state_a !== 4'd1 || ctrl_a !== exp_ctrl(4'd1, 1'b1)) begin
      errors++; $display("FAIL idle_to_fetch: st=%0d ctrl=%b want 1 %b", state_a, ctrl_a, exp_ctrl(4'd1, 1'b1));
    end
    exp_retired = 8'd0;
    exp_flags = 5'd0;
  endtask

  task automatic test_sequence();
    run_instr(OP_R, 0, 0);
    run_instr(OP_LW, 0, 0);
    run_instr(OP_SW, 0, 0);
    run_instr(OP_BEQ, 0, 0);
    run_instr(OP_J, 0, 0);
    checks++;
    if (retired_a !== 8'd5 || flags_a !== 5'b10000) begin
      errors++; $display("FAIL sequence_end: ret=%0d flags=%b want 5 10000", retired_a, flags_a);
    end
  endtask

  task automatic test_stall_lw();
    run_instr(OP_LW, 3, 2);
    checks++;
    if (state_a !== 4'd1) begin
      errors++; $display("FAIL lw_stall_end: got %0d want 1", state_a);
    end
  endtask

  task automatic test_stall_sw();
    run_instr(OP_SW, 0, 2);
  endtask

  task automatic test_random();
    logic [5:0] ops[5];
    ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J};
    for (int n = 0; n < 40; n++) begin
      run_instr(ops[$urandom_range(0, 4)], int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_reset_mid_exec();
    mem_ready = 1'b1;
    @(posedge hand_clock); #1;
    opcode = OP_R;
    @(posedge hand_clock); #1;
    checks++;
    if (state_a !== 4'd7) begin
      errors++; $display("FAIL pre_reset_exec: got %0d want 7", state_a);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (state_a !== 4'd0 || ctrl_a !== 17'd0 || flags_a !== 5'd0 || retired_a !== 8'd0) begin
      errors++; $display("FAIL mid_exec_reset: st=%0d ctrl=%b flags=%b ret=%0d want all 0", state_a, ctrl_a, flags_a, retired_a);
    end
    @(posedge hand_clock); #1;
    reset = 1'b0;
    @(posedge hand_clock); #1;
    mem_ready = 1'b0;
    #1;
    checks++;
    if (state_a !== 4'd1 || mem_read_a !== 1'b1 || alu_src_b_a !== 2'b01 || ctrl_a !== exp_ctrl(4'd1, 1'b0)) begin
      errors++; $display("FAIL after_reset_fetch: st=%0d ctrl=%b want 1 %b", state_a, ctrl_a, exp_ctrl(4'd1, 1'b0));
    end
    exp_retired = 8'd0;
    exp_flags = 5'd0;
  endtask

  task automatic test_trap();
    run_instr(OP_J, 0, 0);
    mem_ready = 1'b1;
    @(posedge hand_clock); #1;
    opcode = OP_BAD;
    mem_ready = 1'($urandom);
    @(posedge hand_clock); #1;
    checks++;
    if (state_a !== 4'd11 || ctrl_a !== 17'd1 || flags_a !== 5'd0) begin
      errors++; $display("FAIL trap_entry: st=%0d ctrl=%b flags=%b want 11 %b 0", state_a, ctrl_a, flags_a, 17'd1);
    end
    checks++;
    if (state_b !== 4'd1 || flags_b !== 5'd0 || retired_b !== exp_retired) begin
      errors++; $display("FAIL skip_illegal: st=%0d flags=%b ret=%0d want 1 0 %0d", state_b, flags_b, retired_b, exp_retired);
    end
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'($urandom);
      opcode = 6'($urandom);
      #1;
      checks++;
      if (state_a !== 4'd11 || halted_a !== 1'b1 || retired_a !== exp_retired) begin
        errors++; $display("FAIL trap_hold cyc=%0d: st=%0d halted=%b ret=%0d want 11 1 %0d", i, state_a, halted_a, retired_a, exp_retired);
      end
      @(posedge hand_clock); #1;
    end
    reset = 1'b1;
    #1;
    checks++;
    if (halted_a !== 1'b0 || state_a !== 4'd0) begin
      errors++; $display("FAIL trap_reset: halted=%b st=%0d want 0 0", halted_a, state_a);
    end
    apply_reset();
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int n = 0; n < 256; n++) begin
      run_instr(OP_J, 0, 0);
      if (n == 254) begin
        checks++;
        if (retired_a !== 8'd255) begin
          errors++; $display("FAIL wrap_255: got %0d want 255", retired_a);
        end
      end
    end
    checks++;
    if (retired_a !== 8'd0) begin
      errors++; $display("FAIL wrap_0: got %0d want 0", retired_a);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequence();
    test_stall_lw();
    test_stall_sw();
    test_random();
    test_reset_mid_exec();
    test_trap();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_cycle_controller.md
Name: multi_cycle_controller

Overview:
- Moore FSM that sequences the shared CPU datapath: one memory port, one ALU, the IR and the PC.
- It replaces the single-cycle decoder when the CPU is rebuilt as a multi-cycle machine stepped by hand_clock.
- It decodes opcode from the already-registered IR, issues per-state datapath enables and mux selects, and waits on a memory-ready handshake.
- It latches instruction-type flags for the LEDs, counts retired instructions and traps on illegal opcodes.

Parameters:
CNT_W, 8, width of retired-instruction counter
TRAP_EN, 1, 1: illegal opcode halts in TRAP; 0: illegal opcode is skipped (back to FETCH)

Ports:
hand_clock  in  1  CPU clock (debounced hand clock)
reset  in  1  asynchronous, active-high reset
opcode  in  6  IR[31:26]
mem_ready  in  1  memory access complete this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero
pc_source  out  2  00 ALU result, 01 ALUOut register, 10 jump target
iord  out  1  memory address select: 0 PC, 1 ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  IR load
mem_to_reg  out  1  write-back select: 1 MDR
reg_dst  out  1  1 rd, 0 rt
reg_write  out  1  GPR write enable
alu_src_a  out  1  0 PC, 1 rs
alu_src_b  out  2  00 rt, 01 const 4, 10 sign-extended imm, 11 sign-extended imm<<2
alu_op  out  2  00 add, 01 sub, 10 funct field
state  out  4  current state code (debug display)
flag_j, flag_r, flag_lw, flag_sw, flag_beq  out  1 each  type of last decoded instruction
halted  out  1  high in TRAP
retired  out  CNT_W  retired-instruction count

Behaviour:
State codes:
- IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, JUMP=10, TRAP=11. Codes 12-15 go to IDLE.

Reset (asynchronous, takes effect immediately, including mid-instruction):
- state=IDLE; all control outputs 0; flags 0; halted 0; retired 0.
- IDLE lasts exactly one hand_clock, then goes to FETCH.

Control outputs are pure decode of state; any output not listed for a state is 0.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write=pc_write=mem_ready. Stay while mem_ready=0, else go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Latch flags from opcode (exactly one set, or none if illegal). Next state by opcode:
  - 000000 -> EXEC
  - 100011 or 101011 -> MEMADR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - other -> TRAP if TRAP_EN=1, else FETCH (not retired)
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Go to MEMRD for lw, MEMWR for sw, decided from the latched flags.
- MEMRD: mem_read=1, iord=1. Wait for mem_ready, then go to MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Then FETCH.
- MEMWR: mem_write=1, iord=1. Wait for mem_ready, then FETCH. mem_write holds high through the whole wait.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Then ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Then FETCH.
- JUMP: pc_write=1, pc_source=10. Then FETCH.
- TRAP: halted=1, all other controls 0. Stays until reset; mem_ready and opcode are ignored.

Retired counter:
- retired increments on the clock edge that leaves MEMWB, ALUWB, BRANCH, JUMP, or MEMWR with mem_ready=1.
- Wraps from 2^CNT_W-1 to 0. Never increments in IDLE, TRAP or while stalled.

Latency with mem_ready held 1 (cycles from FETCH entry to next FETCH entry):
- R=4, lw=5, sw=4, beq=3, j=3.
- Each cycle mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.

Other rules:
- opcode is sampled only in DECODE; changes in any other state are ignored.
- Flags hold their values until the next DECODE.

Test Plan:
- Reset pulse mid-EXEC -> state=0 and every control output 0 in the same cycle; one hand_clock later state=1, mem_read=1, alu_src_b=01.
- Sequence R(000000), lw(100011), sw(101011), beq(000100), j(000010), mem_ready=1 -> state traces 1,2,7,8 / 1,2,3,4,5 / 1,2,3,6 / 1,2,9 / 1,2,10; retired=5; flag_j=1 only at end.
- lw with mem_ready low 3 cycles in FETCH and 2 in MEMRD -> total 10 cycles; ir_write and pc_write pulse only on the ready cycle; retired +1.
- sw with mem_ready low 2 cycles in MEMWR -> mem_write=1 for 3 consecutive cycles, iord=1 throughout, then FETCH.
- Illegal opcode 111111 with TRAP_EN=1 -> state 11, halted=1, retired unchanged, stays for 20 clocks; reset clears halted. With TRAP_EN=0 -> DECODE goes to FETCH, all flags 0.
- 256 j instructions with CNT_W=8 -> retired wraps to 0 at the 256th instruction.
